// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between the S and P
// requesters, plus a one-pixel-per-cycle full-frame clear sweep.
module fb_write_arbiter #(
  parameter int COORD_W = 6,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [COLOR_W-1:0] s_color,
  input  logic               p_valid,
  output logic               p_ready,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic [COLOR_W-1:0] p_color,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               write_en,
  output logic [COORD_W-1:0] write_x,
  output logic [COORD_W-1:0] write_y,
  output logic [COLOR_W-1:0] write_color
);

  localparam int CNT_W = 2 * COORD_W;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rr_p;
  logic [CNT_W-1:0]   cnt;
  logic [COLOR_W-1:0] clr_color;
  logic               idle;
  logic               s_xfer;
  logic               p_xfer;
  logic               clr_go;
  logic               cnt_last;

  assign idle     = (state == IDLE);
  assign s_xfer   = s_valid & s_ready;
  assign p_xfer   = p_valid & p_ready;
  assign clr_go   = idle & clear_start;
  assign cnt_last = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: start on request, return after the last pixel
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (clear_start) state_nxt = CLEAR;
      CLEAR: if (cnt_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants and busy; the port not granted last wins a tie
  always_comb begin
    s_ready    = idle & s_valid & (~p_valid | rr_p);
    p_ready    = idle & p_valid & (~s_valid | ~rr_p);
    clear_busy = ~idle;
  end

  // Round-robin history, sweep counter and latched fill colour
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_p      <= 1'b1;
      cnt       <= '0;
      clr_color <= '0;
    end else begin
      if (p_xfer)      rr_p <= 1'b1;
      else if (s_xfer) rr_p <= 1'b0;
      if (clr_go) begin
        cnt       <= '0;
        clr_color <= clear_color;
      end else if (!idle && !cnt_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered write port; data holds when nothing is issued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_en    <= 1'b0;
      write_x     <= '0;
      write_y     <= '0;
      write_color <= '0;
      clear_done  <= 1'b0;
    end else begin
      write_en   <= 1'b0;
      clear_done <= 1'b0;
      if (!idle) begin
        write_en    <= 1'b1;
        write_x     <= cnt[COORD_W-1:0];
        write_y     <= cnt[CNT_W-1:COORD_W];
        write_color <= clr_color;
        clear_done  <= cnt_last;
      end else if (s_xfer) begin
        write_en    <= 1'b1;
        write_x     <= s_x;
        write_y     <= s_y;
        write_color <= s_color;
      end else if (p_xfer) begin
        write_en    <= 1'b1;
        write_x     <= p_x;
        write_y     <= p_y;
        write_color <= p_color;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: arbitration, clear sweep,
// clear during pending requests, and reset in the middle of a sweep.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [5:0]  s_x = '0;
  logic [5:0]  s_y = '0;
  logic [11:0] s_color = '0;
  logic        p_valid = 1'b0;
  logic        p_ready;
  logic [5:0]  p_x = '0;
  logic [5:0]  p_y = '0;
  logic [11:0] p_color = '0;
  logic        clear_start = 1'b0;
  logic [11:0] clear_color = '0;
  logic        clear_busy;
  logic        clear_done;
  logic        write_en;
  logic [5:0]  write_x;
  logic [5:0]  write_y;
  logic [11:0] write_color;
  logic [31:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .COORD_W(6),
    .COLOR_W(12)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_y        (s_y),
    .s_color    (s_color),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .p_x        (p_x),
    .p_y        (p_y),
    .p_color    (p_color),
    .clear_start(clear_start),
    .clear_color(clear_color),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .write_en   (write_en),
    .write_x    (write_x),
    .write_y    (write_y),
    .write_color(write_color)
  );

  assign obs = {6'b0, clear_done, write_en,
                write_y, write_x, write_color};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] px(input logic d, input logic w,
                                     input int x, input int y,
                                     input int c);
    logic [5:0]  xv;
    logic [5:0]  yv;
    logic [11:0] cv;
    xv = x[5:0];
    yv = y[5:0];
    cv = c[11:0];
    return {6'b0, d, w, yv, xv, cv};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_out", obs, 32'h0);
    chk("rst_busy", {31'b0, clear_busy}, 32'h0);
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_out", obs, 32'h0);
    chk("rst_busy", {31'b0, clear_busy}, 32'h0);
    chk("rst_rdy", {30'b0, s_ready, p_ready}, 32'h0);
    resetn = 1'b1;

    // single S write
    tick();
    s_valid = 1'b1;
    s_x = 6'd5; s_y = 6'd9; s_color = 12'hF00;
    #1;
    chk("t1_rdy", {30'b0, s_ready, p_ready}, 32'h2);
    tick();
    s_valid = 1'b0;
    chk("t1_wr", obs, px(0, 1, 5, 9, 'hF00));
    tick();
    chk("t1_hold", obs, px(0, 0, 5, 9, 'hF00));

    // both valid after reset: S,P,S,P
    do_reset();
    s_x = 6'd1; s_y = 6'd2; s_color = 12'h111;
    p_x = 6'd3; p_y = 6'd4; p_color = 12'h222;
    s_valid = 1'b1;
    p_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_rdy", {30'b0, s_ready, p_ready},
          (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      if (k % 2 == 0) chk("t2_wr", obs, px(0, 1, 1, 2, 'h111));
      else            chk("t2_wr", obs, px(0, 1, 3, 4, 'h222));
    end
    s_valid = 1'b0;
    p_valid = 1'b0;
    tick();
    chk("t2_hold", obs, px(0, 0, 3, 4, 'h222));

    // full clear with 0x00F
    clear_color = 12'h00F;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("t3_busy0", {31'b0, clear_busy}, 32'h1);
    chk("t3_pre", obs, px(0, 0, 3, 4, 'h222));
    for (int k = 0; k < 4096; k++) begin
      tick();
      chk("t3_px", obs,
          px(k == 4095, 1, k % 64, k / 64, 'h00F));
      chk("t3_busy", {31'b0, clear_busy},
          (k == 4095) ? 32'h0 : 32'h1);
    end

    // P raised mid-clear, restart attempt ignored
    clear_color = 12'h0A5;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      chk("t4_px", obs,
          px(k == 4095, 1, k % 64, k / 64, 'h0A5));
      if (k == 100) begin
        p_valid = 1'b1;
        p_x = 6'd7; p_y = 6'd8; p_color = 12'h333;
      end
      if (k == 200) begin
        clear_start = 1'b1;
        clear_color = 12'hFFF;
      end
      if (k == 201) clear_start = 1'b0;
      #1;
      if (k >= 100)
        chk("t4_prdy", {31'b0, p_ready},
            (k == 4095) ? 32'h1 : 32'h0);
    end
    tick();
    p_valid = 1'b0;
    chk("t4_pwr", obs, px(0, 1, 7, 8, 'h333));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_idle", obs, px(0, 0, 7, 8, 'h333));
      chk("t4_busy", {31'b0, clear_busy}, 32'h0);
    end

    // reset at clear pixel 1000
    clear_color = 12'h0F0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k <= 1000; k++) begin
      tick();
      chk("t5_px", obs, px(0, 1, k % 64, k / 64, 'h0F0));
    end
    resetn = 1'b0;
    #1;
    chk("t5_rst", obs, 32'h0);
    chk("t5_busy", {31'b0, clear_busy}, 32'h0);
    tick();
    resetn = 1'b1;
    s_x = 6'd10; s_y = 6'd11; s_color = 12'h456;
    p_x = 6'd12; p_y = 6'd13; p_color = 12'h789;
    s_valid = 1'b1;
    p_valid = 1'b1;
    #1;
    chk("t5_rdy", {30'b0, s_ready, p_ready}, 32'h2);
    tick();
    s_valid = 1'b0;
    p_valid = 1'b0;
    chk("t5_swr", obs, px(0, 1, 10, 11, 'h456));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_idle", obs, px(0, 0, 10, 11, 'h456));
      chk("t5_busy2", {31'b0, clear_busy}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Owns the single framebuffer write port of the LED matrix display (write_en/x/y/color) and shares it between two external requesters: the SPI-fed physics/particle path (port S) and the on-chip pattern generator (port P). Also contains a frame-clear sequencer that sweeps the full 64x64 buffer with one colour at one pixel per cycle. Sits between the requesters and display, all in the int_osc domain.

Parameters:
COORD_W, 6, bits per coordinate; the buffer is 2^COORD_W x 2^COORD_W
COLOR_W, 12, pixel colour width (4:4:4 RGB)

Ports:
clk  in  1  system clock (int_osc)
resetn  in  1  asynchronous active-low reset
s_valid  in  1  port S write request
s_ready  out  1  port S accept (combinational)
s_x, s_y  in  COORD_W each  port S coordinates
s_color  in  COLOR_W  port S colour
p_valid  in  1  port P write request
p_ready  out  1  port P accept (combinational)
p_x, p_y  in  COORD_W each  port P coordinates
p_color  in  COLOR_W  port P colour
clear_start  in  1  one-cycle pulse that starts a full-frame clear
clear_color  in  COLOR_W  fill colour, sampled with clear_start
clear_busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse marking the last clear pixel
write_en  out  1  to display write port
write_x, write_y  out  COORD_W each  to display
write_color  out  COLOR_W  to display

Behaviour:
- Reset (async assert, sync deassert by caller): state IDLE; write_en, write_x, write_y, write_color, clear_busy, clear_done = 0; rr_last = P, so S wins the first tie; clear counter = 0.
- Handshake: a transfer occurs when valid&&ready on a port. A requester holds valid and data stable until accepted. ready never depends on the same port's data.
- Arbitration in IDLE:
  - Only one port valid: that port gets ready=1.
  - Both ports valid: the port not in rr_last gets ready=1. rr_last updates to the granted port on every transfer.
  - At most one ready is high per cycle.
- Output stage is registered with latency 1. The cycle after a transfer: write_en=1, and x/y/color equal the accepted data.
- If no transfer occurs and no clear pixel is issued: write_en=0, and x/y/color hold their last values.
- State machine IDLE/CLEAR:
  - IDLE->CLEAR: clear_start=1 in IDLE. Latch clear_color and set cnt=0. Arbitration still grants in this same cycle.
  - In CLEAR: s_ready=p_ready=0 and clear_busy=1. Each cycle the output stage loads write_en=1, write_x=cnt[COORD_W-1:0], write_y=cnt[2*COORD_W-1:COORD_W], write_color=latched colour. cnt then increments.
  - CLEAR->IDLE: when cnt = 2^(2*COORD_W)-1 is loaded. Arbitration resumes the following cycle.
- clear_busy is high on the cycles CLEAR is the current state: 4096 cycles at default width.
- clear_done=1 on the same cycle that write_en carries pixel (63,63). It is 0 otherwise.
- clear_start in CLEAR is ignored; there is no restart and the latched colour is unchanged.
- The clear counter is 2*COORD_W bits and does not wrap past the last pixel.
- Requests pending during CLEAR are preserved by the holding rule and served round-robin afterwards. rr_last is unchanged by a clear.
- resetn asserted mid-clear or mid-transfer: all state returns to reset values immediately, write_en drops asynchronously, and no clear_done is produced.

Test Plan:
- s_valid only, s=(5,9,0xF00) for 1 cycle -> s_ready=1 the same cycle; next cycle write_en=1, (5,9,0xF00); then write_en=0 with values held.
- s_valid and p_valid held high for 4 cycles after reset -> grants S,P,S,P. Four write_en pulses carry the data in that order, one cycle later each.
- clear_start with clear_color=0x00F while idle -> clear_busy high 4096 cycles. write_en covers (0,0),(1,0)..(63,0),(0,1)..(63,63) in order, colour 0x00F. clear_done coincides with (63,63).
- p_valid raised mid-clear, second clear_start mid-clear -> p_ready=0 until the cycle after the last clear pixel, then P accepted. No second sweep occurs.
- resetn pulsed low at clear pixel 1000 -> write_en=0 and clear_busy=0 immediately, no clear_done. After release, s_valid is accepted normally with S winning the tie vs P.
